// File: rtl/sargantana_icache_pkg.sv
// Shared types and tree-PLRU helpers for the instruction-cache victim selector.
// Helpers work on a max-width (16-way) tree; callers pass the real tree depth.
package sargantana_icache_pkg;

    localparam int unsigned PLRU_MAX_WAYS = 16;
    localparam int unsigned PLRU_MAX_LVLS = 4;

    typedef logic [PLRU_MAX_WAYS-2:0] plru_bits_t;
    typedef logic [PLRU_MAX_LVLS-1:0] plru_way_t;

    // Walk from the root following each node bit; the leaf reached is the victim.
    function automatic plru_way_t plru_victim(input plru_bits_t bits, input int unsigned levels);
        logic [4:0] node;
        logic [4:0] base;
        node = '0;
        for (int unsigned lvl = 0; lvl < PLRU_MAX_LVLS; lvl++) begin
            if (lvl < levels) begin
                node = {node[3:0], 1'b0} + 5'd1 + {4'b0, bits[node[3:0]]};
            end
        end
        base = 5'((32'd1 << levels) - 32'd1);
        return plru_way_t'(node - base);
    endfunction

    // Every node on the accessed way's path is pointed at the opposite subtree.
    function automatic plru_bits_t plru_update(input plru_bits_t bits, input plru_way_t way,
                                               input int unsigned levels);
        plru_bits_t b;
        logic [4:0] node;
        logic       dir;
        b    = bits;
        node = '0;
        for (int unsigned lvl = 0; lvl < PLRU_MAX_LVLS; lvl++) begin
            if (lvl < levels) begin
                dir            = way[2'(levels - 1 - lvl)];
                b[node[3:0]]   = ~dir;
                node           = {node[3:0], 1'b0} + 5'd1 + {4'b0, dir};
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/sargantana_icache_prio_enc.sv
// Lowest-set-bit encoder with an any-set flag.
module sargantana_icache_prio_enc
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (i_vec[i-1]) begin
                o_idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_victim_sel.sv
// Instruction-cache replacement-way selector: lowest invalid way, else per-set tree PLRU.
module sargantana_icache_victim_sel
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned ICACHE_N_WAY  = 4,
    parameter int unsigned ICACHE_N_SETS = 64,
    parameter int unsigned SET_W         = $clog2(ICACHE_N_SETS),
    parameter int unsigned WAY_W         = $clog2(ICACHE_N_WAY)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    input  logic [SET_W-1:0]        req_set_i,
    input  logic [ICACHE_N_WAY-1:0] req_way_valid_i,
    input  logic                    upd_valid_i,
    input  logic [SET_W-1:0]        upd_set_i,
    input  logic [WAY_W-1:0]        upd_way_i,
    output logic                    victim_valid_o,
    output logic [WAY_W-1:0]        victim_way_o,
    output logic                    victim_from_inv_o
);

    localparam int unsigned PLRU_W = ICACHE_N_WAY - 1;
    localparam int unsigned LEVELS = WAY_W;

    logic [PLRU_W-1:0] r_plru [ICACHE_N_SETS];

    logic              r_victim_valid;
    logic [WAY_W-1:0]  r_victim_way;
    logic              r_victim_from_inv;

    logic [PLRU_W-1:0] w_upd_bits;
    logic [PLRU_W-1:0] w_req_bits;
    logic [WAY_W-1:0]  w_walk_way;
    logic [WAY_W-1:0]  w_inv_way;
    logic              w_any_inv;

    sargantana_icache_prio_enc #(
        .WIDTH (ICACHE_N_WAY),
        .IDX_W (WAY_W)
    ) u_inv_enc (
        .i_vec (~req_way_valid_i),
        .o_idx (w_inv_way),
        .o_any (w_any_inv)
    );

    // Same-cycle flush or same-set update is forwarded into the walk.
    always_comb begin
        w_upd_bits = PLRU_W'(plru_update(plru_bits_t'(r_plru[upd_set_i]),
                                         plru_way_t'(upd_way_i), LEVELS));
        w_req_bits = r_plru[req_set_i];
        if (flush_i) begin
            w_req_bits = '0;
        end else if (upd_valid_i && (upd_set_i == req_set_i)) begin
            w_req_bits = w_upd_bits;
        end
        w_walk_way = WAY_W'(plru_victim(plru_bits_t'(w_req_bits), LEVELS));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ICACHE_N_SETS; i++) begin
                r_plru[i] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < ICACHE_N_SETS; i++) begin
                r_plru[i] <= '0;
            end
        end else if (upd_valid_i) begin
            r_plru[upd_set_i] <= w_upd_bits;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_victim_valid    <= 1'b0;
            r_victim_way      <= '0;
            r_victim_from_inv <= 1'b0;
        end else begin
            r_victim_valid <= req_valid_i;
            if (req_valid_i) begin
                r_victim_way      <= w_any_inv ? w_inv_way : w_walk_way;
                r_victim_from_inv <= w_any_inv;
            end
        end
    end

    assign victim_valid_o    = r_victim_valid;
    assign victim_way_o      = r_victim_way;
    assign victim_from_inv_o = r_victim_from_inv;

endmodule

// File: tb/tb_sargantana_icache_victim_sel.sv
// Bench for the victim selector: 4-way and 8-way instances checked against a scoreboard.
module tb_sargantana_icache_victim_sel;

    typedef struct packed {
        logic [3:0] way;
        logic       inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-way instance
    logic       flush4 = 0, req4 = 0, upd4 = 0;
    logic [5:0] req_set4 = '0, upd_set4 = '0;
    logic [3:0] req_vld4 = '0;
    logic [1:0] upd_way4 = '0;
    logic       vv4, inv4;
    logic [1:0] way4;

    // 8-way instance
    logic       flush8 = 0, req8 = 0, upd8 = 0;
    logic [3:0] req_set8 = '0, upd_set8 = '0;
    logic [7:0] req_vld8 = '0;
    logic [2:0] upd_way8 = '0;
    logic       vv8, inv8;
    logic [2:0] way8;

    int   errors = 0;
    int   checks = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic exp_v4, exp_v8;

    sargantana_icache_victim_sel #(.ICACHE_N_WAY(4), .ICACHE_N_SETS(64)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush4),
        .req_valid_i(req4), .req_set_i(req_set4), .req_way_valid_i(req_vld4),
        .upd_valid_i(upd4), .upd_set_i(upd_set4), .upd_way_i(upd_way4),
        .victim_valid_o(vv4), .victim_way_o(way4), .victim_from_inv_o(inv4)
    );

    sargantana_icache_victim_sel #(.ICACHE_N_WAY(8), .ICACHE_N_SETS(16)) dut8 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush8),
        .req_valid_i(req8), .req_set_i(req_set8), .req_way_valid_i(req_vld8),
        .upd_valid_i(upd8), .upd_set_i(upd_set8), .upd_way_i(upd_way8),
        .victim_valid_o(vv8), .victim_way_o(way8), .victim_from_inv_o(inv8)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_v4 <= 1'b0;
            exp_v8 <= 1'b0;
        end else begin
            exp_v4 <= req4;
            exp_v8 <= req8;
        end
    end

    // Scoreboard: one result expected exactly one cycle after each accepted request.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            checks++;
            if (vv4 !== exp_v4) begin
                errors++;
                $display("FAIL valid4 t=%0t got=%b exp=%b", $time, vv4, exp_v4);
            end
            if (vv4 === 1'b1) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL sb4_empty t=%0t got way=%0d inv=%b exp=none", $time, way4, inv4);
                end else begin
                    e = q4.pop_front();
                    if ({4'(way4), inv4} !== e) begin
                        errors++;
                        $display("FAIL victim4 t=%0t got way=%0d inv=%b exp way=%0d inv=%b",
                                 $time, way4, inv4, e.way, e.inv);
                    end
                end
            end
            checks++;
            if (vv8 !== exp_v8) begin
                errors++;
                $display("FAIL valid8 t=%0t got=%b exp=%b", $time, vv8, exp_v8);
            end
            if (vv8 === 1'b1) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL sb8_empty t=%0t got way=%0d inv=%b exp=none", $time, way8, inv8);
                end else begin
                    e = q8.pop_front();
                    if ({4'(way8), inv8} !== e) begin
                        errors++;
                        $display("FAIL victim8 t=%0t got way=%0d inv=%b exp way=%0d inv=%b",
                                 $time, way8, inv8, e.way, e.inv);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        req4 = 0; upd4 = 0; flush4 = 0;
        req8 = 0; upd8 = 0; flush8 = 0;
    endtask

    task automatic push_req4(input logic [5:0] set, input logic [3:0] vld,
                             input int way, input logic inv);
        req4 = 1; req_set4 = set; req_vld4 = vld;
        q4.push_back('{way: 4'(way), inv: inv});
    endtask

    task automatic push_req8(input logic [3:0] set, input logic [7:0] vld,
                             input int way, input logic inv);
        req8 = 1; req_set8 = set; req_vld8 = vld;
        q8.push_back('{way: 4'(way), inv: inv});
    endtask

    task automatic set_upd4(input logic [5:0] set, input logic [1:0] way);
        upd4 = 1; upd_set4 = set; upd_way4 = way;
    endtask

    task automatic set_upd8(input logic [3:0] set, input logic [2:0] way);
        upd8 = 1; upd_set8 = set; upd_way8 = way;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({vv4, way4, inv4} !== 4'b0) begin
            errors++;
            $display("FAIL reset4 got v=%b way=%0d inv=%b exp all 0", vv4, way4, inv4);
        end
        checks++;
        if ({vv8, way8, inv8} !== 5'b0) begin
            errors++;
            $display("FAIL reset8 got v=%b way=%0d inv=%b exp all 0", vv8, way8, inv8);
        end
        #19 rst = 0;
        step();
        push_req4(6'd3, 4'b1111, 0, 1'b0);
        step();
    endtask

    task automatic test_invalid_select();
        push_req4(6'd7, 4'b1011, 2, 1'b1); step();
        push_req4(6'd7, 4'b1111, 0, 1'b0); step();
        push_req4(6'd7, 4'b1110, 0, 1'b1); step();
        push_req4(6'd7, 4'b0000, 0, 1'b1); step();
        push_req4(6'd7, 4'b0111, 3, 1'b1); step();
    endtask

    task automatic test_plru_update();
        set_upd4(6'd5, 2'd0); step();
        set_upd4(6'd5, 2'd2); step();
        push_req4(6'd5, 4'b1111, 1, 1'b0); step();
        set_upd4(6'd5, 2'd1); step();
        push_req4(6'd5, 4'b1111, 3, 1'b0); step();
    endtask

    task automatic test_forwarding();
        set_upd4(6'd9, 2'd0);
        push_req4(6'd9, 4'b1111, 2, 1'b0); step();
        set_upd4(6'd10, 2'd0);
        push_req4(6'd11, 4'b1111, 0, 1'b0); step();
        push_req4(6'd10, 4'b1111, 2, 1'b0); step();
    endtask

    task automatic test_flush();
        flush4 = 1; step();
        push_req4(6'd5, 4'b1111, 0, 1'b0); step();
        set_upd4(6'd5, 2'd0); step();
        flush4 = 1; set_upd4(6'd5, 2'd3); step();
        push_req4(6'd5, 4'b1111, 0, 1'b0); step();
        set_upd4(6'd5, 2'd0); step();
        flush4 = 1; push_req4(6'd5, 4'b1111, 0, 1'b0); step();
        // Output register must survive a flush.
        push_req4(6'd7, 4'b1011, 2, 1'b1); step();
        flush4 = 1; step();
        checks++;
        if (way4 !== 2'd2 || inv4 !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold got way=%0d inv=%b exp way=2 inv=1", way4, inv4);
        end
    endtask

    task automatic test_back_to_back();
        push_req4(6'd20, 4'b1101, 1, 1'b1); step();
        push_req4(6'd21, 4'b1111, 0, 1'b0); step();
        push_req4(6'd22, 4'b0011, 2, 1'b1); step();
        step();
    endtask

    task automatic test_way8();
        push_req8(4'd0, 8'hFF, 0, 1'b0); step();
        push_req8(4'd0, 8'b01111111, 7, 1'b1); step();
        set_upd8(4'd1, 3'd0); step();
        push_req8(4'd1, 8'hFF, 4, 1'b0); step();
        set_upd8(4'd1, 3'd4);
        push_req8(4'd1, 8'hFF, 2, 1'b0); step();
    endtask

    task automatic test_async_reset();
        push_req4(6'd30, 4'b0111, 3, 1'b1);
        push_req8(4'd2, 8'b01111111, 7, 1'b1);
        @(posedge clk);
        #1;
        req4 = 0; req8 = 0;
        checks++;
        if (vv4 !== 1'b1 || way4 !== 2'd3) begin
            errors++;
            $display("FAIL pre_rst4 got v=%b way=%0d exp v=1 way=3", vv4, way4);
        end
        void'(q4.pop_front());
        void'(q8.pop_front());
        #1 rst = 1;
        #1;
        checks++;
        if ({vv4, way4, inv4} !== 4'b0) begin
            errors++;
            $display("FAIL async_rst4 got v=%b way=%0d inv=%b exp all 0", vv4, way4, inv4);
        end
        checks++;
        if ({vv8, way8, inv8} !== 5'b0) begin
            errors++;
            $display("FAIL async_rst8 got v=%b way=%0d inv=%b exp all 0", vv8, way8, inv8);
        end
        #4 rst = 0;
        step();
        push_req4(6'd9, 4'b1111, 0, 1'b0);
        push_req8(4'd1, 8'hFF, 0, 1'b0);
        step();
        push_req8(4'd3, 8'b01111111, 7, 1'b1); step();
    endtask

    task automatic drain();
        int budget = 20;
        while ((q4.size() != 0 || q8.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        step();
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL drain got pending4=%0d pending8=%0d exp 0", q4.size(), q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_invalid_select();
        test_plru_update();
        test_forwarding();
        test_flush();
        test_back_to_back();
        test_way8();
        test_async_reset();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
